// File: rtl/tour_pkg.sv
// ----------------------------------------------------------------------------
// tour_pkg
//   Shared types and constants for the knight's-tour move sequencer:
//   FSM state enum, cmd_proc opcodes, heading codes, UART response bytes,
//   and the decoded-move record produced by move_decode.
//   No ports (package). Related build macro: FANFARE_EN (used in move_decode).
// ----------------------------------------------------------------------------
package tour_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        VERT   = 3'd1,
        WAIT_V = 3'd2,
        HORZ   = 3'd3,
        WAIT_H = 3'd4
    } state_t;

    // cmd_proc opcodes
    localparam logic [3:0] MOVE         = 4'b0010;
    localparam logic [3:0] MOVE_FANFARE = 4'b0011;

    // Headings as understood by cmd_proc
    localparam logic [7:0] HDG_N = 8'h00;
    localparam logic [7:0] HDG_W = 8'h3F;
    localparam logic [7:0] HDG_S = 8'h7F;
    localparam logic [7:0] HDG_E = 8'hBF;

    // Response bytes back to RemoteComm
    localparam logic [7:0] RESP_POS_ACK = 8'hA5;
    localparam logic [7:0] RESP_INTERIM = 8'h5A;

    typedef struct packed {
        logic [15:0] vert_cmd;
        logic [15:0] horz_cmd;
        logic        invalid;
    } mv_dec_t;

    function automatic logic [15:0] make_cmd(input logic [3:0] op,
                                             input logic [7:0] hdg,
                                             input logic [3:0] sq);
        return {op, hdg, sq};
    endfunction

endpackage

// File: rtl/move_decode.sv
// ----------------------------------------------------------------------------
// move_decode
//   Combinational decode of a one-hot knight move into two cmd_proc commands:
//   a vertical leg (N/S, |dy| squares) and a horizontal leg (E/W, |dx|).
//   Anything that is not exactly one-hot is flagged invalid.
//   Build macro FANFARE_EN: when defined, the horizontal leg uses the
//   move-with-fanfare opcode; otherwise the plain move opcode.
// Ports
//   move  in  8        one-hot move code
//   dec   out mv_dec_t {vert_cmd, horz_cmd, invalid}
// ----------------------------------------------------------------------------
module move_decode
    import tour_pkg::*;
(
    input  logic [7:0] move,
    output mv_dec_t    dec
);

`ifdef FANFARE_EN
    localparam logic [3:0] HORZ_OP = MOVE_FANFARE;
`else
    localparam logic [3:0] HORZ_OP = MOVE;
`endif

    logic       dx_pos;
    logic       dy_pos;
    logic [3:0] dx_mag;
    logic [3:0] dy_mag;
    logic       invalid;

    // Sign/magnitude table; keeps the legs free of signed arithmetic.
    always_comb begin
        dx_pos  = 1'b0;
        dy_pos  = 1'b0;
        dx_mag  = 4'd0;
        dy_mag  = 4'd0;
        invalid = 1'b0;
        unique case (move)
            8'h01:   begin dx_pos = 1'b1; dx_mag = 4'd1; dy_pos = 1'b1; dy_mag = 4'd2; end
            8'h02:   begin dx_pos = 1'b0; dx_mag = 4'd1; dy_pos = 1'b1; dy_mag = 4'd2; end
            8'h04:   begin dx_pos = 1'b0; dx_mag = 4'd2; dy_pos = 1'b1; dy_mag = 4'd1; end
            8'h08:   begin dx_pos = 1'b0; dx_mag = 4'd2; dy_pos = 1'b0; dy_mag = 4'd1; end
            8'h10:   begin dx_pos = 1'b0; dx_mag = 4'd1; dy_pos = 1'b0; dy_mag = 4'd2; end
            8'h20:   begin dx_pos = 1'b1; dx_mag = 4'd1; dy_pos = 1'b0; dy_mag = 4'd2; end
            8'h40:   begin dx_pos = 1'b1; dx_mag = 4'd2; dy_pos = 1'b0; dy_mag = 4'd1; end
            8'h80:   begin dx_pos = 1'b1; dx_mag = 4'd2; dy_pos = 1'b1; dy_mag = 4'd1; end
            default: invalid = 1'b1;  // zero or multi-hot
        endcase
    end

    always_comb begin
        dec.vert_cmd = make_cmd(MOVE,    dy_pos ? HDG_N : HDG_S, dy_mag);
        dec.horz_cmd = make_cmd(HORZ_OP, dx_pos ? HDG_E : HDG_W, dx_mag);
        dec.invalid  = invalid;
    end

endmodule

// File: rtl/tour_move_sequencer.sv
// ----------------------------------------------------------------------------
// tour_move_sequencer
//   Turns a solved knight's tour into cmd_proc commands (vertical leg, then
//   horizontal leg per move) and arbitrates cmd_proc between the UART path
//   and the tour. Also selects the response byte returned to RemoteComm.
//   Build macro FANFARE_EN selects the horizontal-leg opcode (see move_decode).
// Parameters
//   NUM_MOVES  moves in a full tour
//   IDX_W      width of mv_indx (2**IDX_W >= NUM_MOVES)
// Ports
//   clk, rst      clock; synchronous active-high reset
//   start_tour    pulse: tour solved, begin sequencing
//   move          one-hot move for mv_indx from the solver
//   mv_indx       index of the move being executed
//   cmd_UART      UART command / cmd_rdy_UART its valid
//   clr_cmd_rdy   cmd_proc consumed the command
//   send_resp     cmd_proc finished a command (pulse)
//   cmd, cmd_rdy  command and valid to cmd_proc
//   resp          response byte to the UART wrapper
//   tour_busy     tour owns cmd_proc
//   mv_err        sticky: a non-one-hot move was seen
// ----------------------------------------------------------------------------
module tour_move_sequencer
    import tour_pkg::*;
#(
    parameter int NUM_MOVES = 24,
    parameter int IDX_W     = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_tour,
    input  logic [7:0]       move,
    output logic [IDX_W-1:0] mv_indx,
    input  logic [15:0]      cmd_UART,
    input  logic             cmd_rdy_UART,
    input  logic             clr_cmd_rdy,
    input  logic             send_resp,
    output logic [15:0]      cmd,
    output logic             cmd_rdy,
    output logic [7:0]       resp,
    output logic             tour_busy,
    output logic             mv_err
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_MOVES - 1);

    state_t           state,        state_nxt;
    logic [IDX_W-1:0] idx_nxt;
    logic             err_nxt;
    logic [15:0]      cmd_tour,     cmd_tour_nxt;
    logic             cmd_rdy_tour, rdy_nxt;
    mv_dec_t          dec;

    move_decode u_dec (
        .move (move),
        .dec  (dec)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            mv_indx      <= '0;
            mv_err       <= 1'b0;
            cmd_tour     <= '0;
            cmd_rdy_tour <= 1'b0;
        end else begin
            state        <= state_nxt;
            mv_indx      <= idx_nxt;
            mv_err       <= err_nxt;
            cmd_tour     <= cmd_tour_nxt;
            cmd_rdy_tour <= rdy_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        idx_nxt      = mv_indx;
        err_nxt      = mv_err;
        cmd_tour_nxt = cmd_tour;
        rdy_nxt      = cmd_rdy_tour;
        unique case (state)
            IDLE: begin
                rdy_nxt = 1'b0;
                if (start_tour) begin
                    state_nxt = VERT;
                    idx_nxt   = '0;
                end
            end
            VERT: begin
                if (dec.invalid) begin
                    // Bad solver output: abandon the tour without a command.
                    err_nxt   = 1'b1;
                    rdy_nxt   = 1'b0;
                    state_nxt = IDLE;
                end else begin
                    cmd_tour_nxt = dec.vert_cmd;
                    rdy_nxt      = 1'b1;
                    state_nxt    = WAIT_V;
                end
            end
            WAIT_V: begin
                // clr and send_resp in one cycle are both acted on.
                if (clr_cmd_rdy) rdy_nxt = 1'b0;
                if (send_resp)   state_nxt = HORZ;
            end
            HORZ: begin
                cmd_tour_nxt = dec.horz_cmd;
                rdy_nxt      = 1'b1;
                state_nxt    = WAIT_H;
            end
            WAIT_H: begin
                if (clr_cmd_rdy) rdy_nxt = 1'b0;
                if (send_resp) begin
                    if (mv_indx == LAST) begin
                        rdy_nxt   = 1'b0;
                        state_nxt = IDLE;
                    end else begin
                        idx_nxt   = mv_indx + IDX_W'(1);
                        state_nxt = VERT;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // cmd_proc mux: UART owns it only while idle.
    always_comb begin
        if (state == IDLE) begin
            cmd     = cmd_UART;
            cmd_rdy = cmd_rdy_UART;
        end else begin
            cmd     = cmd_tour;
            cmd_rdy = cmd_rdy_tour;
        end
    end

    // Interim ack for every tour leg except the last horizontal one.
    always_comb begin
        if (state == IDLE || (state == WAIT_H && mv_indx == LAST))
            resp = RESP_POS_ACK;
        else
            resp = RESP_INTERIM;
    end

    assign tour_busy = (state != IDLE);

endmodule

// File: tb/tb_tour_move_sequencer.sv
module tb_tour_move_sequencer;

`ifdef FANFARE_EN
    localparam logic [3:0] HOP = 4'b0011;
`else
    localparam logic [3:0] HOP = 4'b0010;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;

    // DUT a: single-move tour
    logic        a_start = 0, a_clr = 0, a_send = 0, a_rdy_u = 0;
    logic [7:0]  a_move = 8'h01;
    logic [15:0] a_cmd_u = 16'h0;
    logic [4:0]  a_mv_indx;
    logic [15:0] a_cmd;
    logic        a_cmd_rdy, a_busy, a_err;
    logic [7:0]  a_resp;

    // DUT b: full 24-move tour
    logic        b_start = 0, b_clr = 0, b_send = 0, b_rdy_u = 0;
    logic [7:0]  b_move;
    logic [15:0] b_cmd_u = 16'h0;
    logic [4:0]  b_mv_indx;
    logic [15:0] b_cmd;
    logic        b_cmd_rdy, b_busy, b_err;
    logic [7:0]  b_resp;

    logic [7:0] mv_tab [32];
    int         bits   [24];
    assign b_move = mv_tab[b_mv_indx];   // solver model: move table indexed by mv_indx

    tour_move_sequencer #(.NUM_MOVES(1), .IDX_W(5)) u_a (
        .clk(clk), .rst(rst), .start_tour(a_start), .move(a_move), .mv_indx(a_mv_indx),
        .cmd_UART(a_cmd_u), .cmd_rdy_UART(a_rdy_u), .clr_cmd_rdy(a_clr), .send_resp(a_send),
        .cmd(a_cmd), .cmd_rdy(a_cmd_rdy), .resp(a_resp), .tour_busy(a_busy), .mv_err(a_err)
    );

    tour_move_sequencer #(.NUM_MOVES(24), .IDX_W(5)) u_b (
        .clk(clk), .rst(rst), .start_tour(b_start), .move(b_move), .mv_indx(b_mv_indx),
        .cmd_UART(b_cmd_u), .cmd_rdy_UART(b_rdy_u), .clr_cmd_rdy(b_clr), .send_resp(b_send),
        .cmd(b_cmd), .cmd_rdy(b_cmd_rdy), .resp(b_resp), .tour_busy(b_busy), .mv_err(b_err)
    );

    int total = 0;
    int bad   = 0;
    int ncmd, n5a, na5;

    // Knight move table: bit -> (dx, dy)
    int dx_t [8] = '{1, -1, -2, -2, -1, 1, 2, 2};
    int dy_t [8] = '{2, 2, 1, -1, -2, -2, -1, 1};

    function automatic logic [15:0] leg(input int b, input bit vert);
        int d;
        logic [7:0] hdg;
        logic [3:0] op;
        if (vert) begin
            d = dy_t[b]; op = 4'b0010; hdg = (d > 0) ? 8'h00 : 8'h7F;
        end else begin
            d = dx_t[b]; op = HOP;     hdg = (d > 0) ? 8'hBF : 8'h3F;
        end
        if (d < 0) d = -d;
        return {op, hdg, 4'(d)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start;
        b_start = 1'b1;
        tick;
        b_start = 1'b0;
    endtask

    // cmd_proc model for DUT b: wait for a command, consume it, acknowledge.
    task automatic serve(input logic [15:0] ec, input logic [7:0] er, input string tag);
        int mode;
        for (int n = 0; n < 12 && b_cmd_rdy !== 1'b1; n++) tick;
        chk({tag, "_rdy"}, 32'(b_cmd_rdy), 32'd1);
        chk({tag, "_cmd"}, 32'(b_cmd), 32'(ec));
        ncmd++;
        mode = $urandom_range(0, 2);
        if (mode == 1) begin
            b_clr = 1'b1; b_send = 1'b1;
        end else begin
            b_clr = 1'b1;
            tick;
            b_clr = 1'b0;
            chk({tag, "_drop"}, 32'(b_cmd_rdy), 32'd0);
            repeat ($urandom_range(0, 3)) tick;
            b_send = 1'b1;
        end
        chk({tag, "_resp"}, 32'(b_resp), 32'(er));
        if (b_resp === 8'h5A) n5a++;
        else if (b_resp === 8'hA5) na5++;
        tick;
        b_clr = 1'b0; b_send = 1'b0;
    endtask

    task automatic fill_tour;
        for (int i = 0; i < 24; i++) begin
            bits[i]   = $urandom_range(0, 7);
            mv_tab[i] = 8'(1 << bits[i]);
        end
    endtask

    task automatic run_tour;
        fill_tour;
        ncmd = 0; n5a = 0; na5 = 0;
        pulse_start;
        for (int i = 0; i < 24; i++) begin
            if (i == 7) b_start = 1'b1;      // must be ignored while busy
            serve(leg(bits[i], 1'b1), 8'h5A, "vert");
            b_start = 1'b0;
            chk("tour_idx", 32'(b_mv_indx), 32'(i));
            serve(leg(bits[i], 1'b0), (i == 23) ? 8'hA5 : 8'h5A, "horz");
        end
        chk("tour_ncmd", 32'(ncmd), 32'd48);
        chk("tour_n5a",  32'(n5a),  32'd47);
        chk("tour_na5",  32'(na5),  32'd1);
        chk("tour_idx_end", 32'(b_mv_indx), 32'd23);
        chk("tour_done_busy", 32'(b_busy), 32'd0);
    endtask

    initial begin
        int k;
        logic [15:0] u;
        for (int i = 0; i < 32; i++) mv_tab[i] = 8'h01;

        // 1: reset and UART passthrough
        a_rdy_u = 1'b1; a_cmd_u = 16'h2004;
        b_rdy_u = 1'b1; b_cmd_u = 16'h2004;
        tick; tick;
        rst = 1'b0;
        tick;
        chk("rst_a_cmd",  32'(a_cmd), 32'h2004);
        chk("rst_a_rdy",  32'(a_cmd_rdy), 32'd1);
        chk("rst_a_busy", 32'(a_busy), 32'd0);
        chk("rst_a_resp", 32'(a_resp), 32'hA5);
        chk("rst_b_cmd",  32'(b_cmd), 32'h2004);
        chk("rst_b_idx",  32'(b_mv_indx), 32'd0);
        chk("rst_b_err",  32'(b_err), 32'd0);

        // 2: single-move tour on DUT a, UART valid held high (must be ignored)
        a_start = 1'b1; tick; a_start = 1'b0;
        chk("a_busy",   32'(a_busy), 32'd1);
        chk("a_vert_lat0", 32'(a_cmd_rdy), 32'd0);
        tick;
        chk("a_vert_rdy", 32'(a_cmd_rdy), 32'd1);
        chk("a_vert_cmd", 32'(a_cmd), 32'h2002);
        a_clr = 1'b1; a_send = 1'b1;
        chk("a_vert_resp", 32'(a_resp), 32'h5A);
        tick;
        a_clr = 1'b0; a_send = 1'b0;
        chk("a_horz_lat0", 32'(a_cmd_rdy), 32'd0);
        tick;
        chk("a_horz_rdy", 32'(a_cmd_rdy), 32'd1);
        chk("a_horz_cmd", 32'(a_cmd), 32'({HOP, 12'hBF1}));
        a_clr = 1'b1; a_send = 1'b1;
        chk("a_final_resp", 32'(a_resp), 32'hA5);
        tick;
        a_clr = 1'b0; a_send = 1'b0;
        chk("a_end_busy", 32'(a_busy), 32'd0);
        chk("a_end_cmd",  32'(a_cmd), 32'h2004);
        chk("a_end_rdy",  32'(a_cmd_rdy), 32'd1);

        // 4: full random tours on DUT b
        b_rdy_u = 1'b0;
        run_tour;
        run_tour;

        // 5: zero move mid-tour, then a normal tour
        fill_tour;
        k = $urandom_range(1, 5);
        mv_tab[k] = 8'h00;
        pulse_start;
        for (int i = 0; i < k; i++) begin
            serve(leg(bits[i], 1'b1), 8'h5A, "e_vert");
            serve(leg(bits[i], 1'b0), 8'h5A, "e_horz");
        end
        chk("err_vert_rdy",  32'(b_cmd_rdy), 32'd0);
        chk("err_vert_busy", 32'(b_busy), 32'd1);
        tick;
        chk("err_set",  32'(b_err), 32'd1);
        chk("err_idle", 32'(b_busy), 32'd0);
        chk("err_rdy",  32'(b_cmd_rdy), 32'd0);
        run_tour;
        chk("err_sticky", 32'(b_err), 32'd1);

        // 3 + 6: move 8'h08 decode, then reset while in WAIT_H
        mv_tab[0] = 8'h08;
        ncmd = 0; n5a = 0; na5 = 0;
        pulse_start;
        serve(16'h27F1, 8'h5A, "m08_vert");
        for (int n = 0; n < 12 && b_cmd_rdy !== 1'b1; n++) tick;
        chk("m08_horz_rdy", 32'(b_cmd_rdy), 32'd1);
        chk("m08_horz_cmd", 32'(b_cmd), 32'({HOP, 12'h3F2}));
        u = 16'($urandom);
        b_rdy_u = 1'b1; b_cmd_u = u;
        rst = 1'b1;
        tick;
        chk("abort_busy", 32'(b_busy), 32'd0);
        chk("abort_rdy",  32'(b_cmd_rdy), 32'd1);
        chk("abort_cmd",  32'(b_cmd), 32'(u));
        chk("abort_idx",  32'(b_mv_indx), 32'd0);
        chk("abort_err",  32'(b_err), 32'd0);
        chk("abort_resp", 32'(b_resp), 32'hA5);
        rst = 1'b0;
        tick;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Overall watchdog so the run always ends.
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
